// File: rtl/syscall_service.sv
// syscall_service: console/exit service engine for the core.
// Runs print-int, print-string, print-char and exit requests.
module syscall_service #(
  parameter int MAX_STR = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STR_FETCH,
    S_STR_SEND,
    S_INT_CONV,
    S_INT_SEND,
    S_CHAR_SEND,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a0_q, a0_d;
  logic [31:0] idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic [31:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  dig_q [10];
  logic [3:0]  dig_d [10];
  logic        err_q, err_d;

  logic        fire;
  logic [7:0]  fbyte;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [3:0]  dsel;
  logic [3:0]  cur_dig;

  // Output decode from registered state
  always_comb begin
    stall    = (state_q != S_IDLE);
    halted   = (state_q == S_HALT);
    err      = err_q;
    tx_valid = (state_q == S_STR_SEND) ||
               (state_q == S_INT_SEND) ||
               (state_q == S_CHAR_SEND);
    mem_addr = (state_q == S_STR_FETCH) ? a0_q + idx_q : 32'd0;
    dsel     = cnt_q - 4'd1;
    cur_dig  = 4'd0;
    for (int i = 0; i < 10; i++)
      if (dsel == i[3:0]) cur_dig = dig_q[i];
    unique case (state_q)
      S_CHAR_SEND: tx_data = a0_q[7:0];
      S_STR_SEND:  tx_data = byte_q;
      S_INT_SEND:  tx_data = neg_q ? 8'h2D : {4'h3, cur_dig};
      default:     tx_data = 8'h00;
    endcase
  end

  // Big-endian byte lane select for string fetch
  always_comb begin
    unique case (mem_addr[1:0])
      2'd0: fbyte = mem_rdata[31:24];
      2'd1: fbyte = mem_rdata[23:16];
      2'd2: fbyte = mem_rdata[15:8];
      default: fbyte = mem_rdata[7:0];
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a0_d    = a0_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    err_d   = 1'b0;
    fire    = tx_valid && tx_ready;
    quo     = mag_q / 32'd10;
    rem     = mag_q % 32'd10;
    unique case (state_q)
      S_IDLE: begin
        if (syscall) begin
          a0_d  = a0;
          idx_d = 32'd0;
          cnt_d = 4'd0;
          neg_d = a0[31];
          mag_d = a0[31] ? (~a0 + 32'd1) : a0;
          unique case (v0)
            32'd1:   state_d = S_INT_CONV;
            32'd4:   state_d = S_STR_FETCH;
            32'd10:  state_d = S_HALT;
            32'd11:  state_d = S_CHAR_SEND;
            default: err_d = 1'b1;
          endcase
        end
      end
      S_STR_FETCH: begin
        if (fbyte == 8'h00 || idx_q == 32'(MAX_STR)) begin
          state_d = S_IDLE;
        end else begin
          byte_d  = fbyte;
          state_d = S_STR_SEND;
        end
      end
      S_STR_SEND: begin
        if (fire) begin
          idx_d   = idx_q + 32'd1;
          state_d = S_STR_FETCH;
        end
      end
      S_INT_CONV: begin
        for (int i = 0; i < 10; i++)
          if (cnt_q == i[3:0]) dig_d[i] = rem[3:0];
        mag_d = quo;
        cnt_d = cnt_q + 4'd1;
        if (quo == 32'd0) state_d = S_INT_SEND;
      end
      S_INT_SEND: begin
        if (fire) begin
          if (neg_q) begin
            neg_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_IDLE;
          end
        end
      end
      S_CHAR_SEND: begin
        if (fire) state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a0_q    <= 32'd0;
      idx_q   <= 32'd0;
      byte_q  <= 8'd0;
      mag_q   <= 32'd0;
      neg_q   <= 1'b0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < 10; i++) dig_q[i] <= 4'd0;
    end else begin
      state_q <= state_d;
      a0_q    <= a0_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
    end
  end

endmodule

// File: doc/syscall_service.md
SYSCALL_SERVICE -- requirements
Module: syscall_service

Interface
REQ-001 Parameter: MAX_STR, default 256, maximum bytes emitted per print-string request.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 syscall  input  1  service request from core; sampled only in IDLE.
REQ-005 v0  input  32  service code ($v0).
REQ-006 a0  input  32  argument ($a0).
REQ-007 stall  output  1  core freeze; high whenever state != IDLE.
REQ-008 mem_addr  output  32  data-memory byte address for string fetch.
REQ-009 mem_rdata  input  32  word at {mem_addr[31:2],2'b00}, valid same cycle (combinational read).
REQ-010 tx_data  output  8  console character.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  console accepts character.
REQ-013 halted  output  1  exit service executed.
REQ-014 err  output  1  one-cycle pulse on unknown service code.

Function
REQ-015 States: IDLE, STR_FETCH, STR_SEND, INT_CONV, INT_SEND, CHAR_SEND, HALT.
REQ-016 Accept: syscall=1 in IDLE latches v0/a0; the next state is selected by the latched code; stall rises on the following cycle.
REQ-017 Code 1 (print int) -> INT_CONV; code 4 (print string) -> STR_FETCH; code 10 (exit) -> HALT; code 11 (print char) -> CHAR_SEND; any other code -> err=1 for one cycle, remain IDLE, no output.
REQ-018 Transfer occurs on a cycle with tx_valid=1 and tx_ready=1; while tx_valid=1 and tx_ready=0, tx_data SHALL hold stable.
REQ-019 CHAR_SEND: tx_data=a0[7:0], tx_valid=1; after transfer -> IDLE.
REQ-020 STR_FETCH: mem_addr=a0+idx (idx starts at 0, 32-bit wraparound add); byte select is big-endian: addr[1:0]=0 -> rdata[31:24], 3 -> rdata[7:0].
REQ-021 STR_FETCH: if the fetched byte = 0x00 or idx = MAX_STR -> IDLE; otherwise register the byte -> STR_SEND.
REQ-022 STR_SEND: present the byte; on transfer, idx+1 -> STR_FETCH.
REQ-023 INT_CONV: treat a0 as signed; magnitude = |a0| as 32-bit unsigned (0x80000000 -> 2147483648).
REQ-024 INT_CONV: one digit per cycle (mag%10 into a 10-entry digit buffer, mag/10); stop when mag=0 after at least one digit; a0=0 yields the single digit '0'.
REQ-025 INT_SEND: emit '-' (0x2D) first if a0<0; then emit ASCII digits most-significant first; after the last transfer -> IDLE.
REQ-026 HALT: halted=1 and stall=1 permanently; syscall is ignored; only reset exits.
REQ-027 tx_valid=0 in IDLE, STR_FETCH, INT_CONV and HALT.
REQ-028 mem_addr=0 outside STR_FETCH.
REQ-029 syscall asserted while not in IDLE SHALL be ignored.

Reset
REQ-030 reset=1 at any clock edge, including mid-string or mid-conversion: state=IDLE, idx=0, stall=0, tx_valid=0, tx_data=0, halted=0, err=0, mem_addr=0, digit buffer cleared; effective on that edge.
REQ-031 Any partially emitted output is abandoned; no character is transferred on the cycle following reset.

Verification
REQ-032 v0=1, a0=0xFFFFF85B (-1957), tx_ready=1 -> transferred sequence "-1957"; stall high from acceptance+1 until return to IDLE; then stall=0.
REQ-033 v0=1 with a0=0x80000000 -> "-2147483648"; a0=0 -> "0"; a0=7 -> "7".
REQ-034 v0=4, a0=0x1001, memory bytes at 0x1001.. = "Hi!\0", tx_ready toggled 0/1 each cycle -> "Hi!" transferred with tx_data stable during stalls; addresses 0x1001-0x1004 fetched.
REQ-035 v0=4 on a string of 300 non-zero bytes with MAX_STR=256 -> exactly 256 transfers, then IDLE.
REQ-036 v0=10 -> halted=1 and stall=1 persist for 20 cycles with syscall pulses applied; reset -> halted=0, IDLE; v0=99 -> single err pulse, no tx_valid.
REQ-037 reset asserted after the 2nd character of "Hello" -> next cycle tx_valid=0, stall=0; a new v0=11, a0=0x41 request -> single 'A' transfer.
